mult_bus_if: RTL

MULT_BUS_IF -- requirements
Module: mult_bus_if

---
 rtl/mult_bus_if_if.sv | 27 ++
 rtl/mult_bus_if.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mult_bus_if_if.sv
// Bus and multiplier-core signal bundle for mult_bus_if.
// master = host bus plus core side, slave = the register wrapper.
interface mult_bus_if_if #(
    parameter int WIDTH = 16
);
    logic                 cs;
    logic                 we;
    logic                 rd;
    logic [2:0]           addr;
    logic [31:0]          d_in;
    logic [31:0]          d_out;
    logic [WIDTH-1:0]     op_A;
    logic [WIDTH-1:0]     op_B;
    logic                 init;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output cs, we, rd, addr, d_in, done, result,
        input  d_out, op_A, op_B, init
    );

    modport slave (
        input  cs, we, rd, addr, d_in, done, result,
        output d_out, op_A, op_B, init
    );
endinterface

// File: rtl/mult_bus_if.sv
// Register-mapped front end for a multi-cycle multiplier core; reads return data one cycle after cs&rd.
// Starts are accepted only in IDLE; the core is drained (done low) before another start can fire it.
module mult_bus_if #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mult_bus_if_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FIRE  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [2:0] ADDR_A      = 3'd0;
    localparam logic [2:0] ADDR_B      = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;

    logic [2:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [2*WIDTH-1:0] res_q;
    logic               err;
    logic               done_flag;
    logic [31:0]        d_out_q;
    logic [31:0]        rd_data;
    logic               wr_en;
    logic               rd_en;
    logic               start;
    logic               busy;
    logic               unused_d_in;

    assign wr_en = bus.cs & bus.we;
    assign rd_en = bus.cs & bus.rd;
    assign start = wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[0];
    assign busy  = (state != S_IDLE);

    assign unused_d_in = ^bus.d_in;

    // Read mux looks at current register contents, so a same-cycle write is not visible.
    always_comb begin
        rd_data = 32'd0;
        case (bus.addr)
            ADDR_STATUS: rd_data = {29'd0, err, done_flag, busy};
            ADDR_RESULT: rd_data = 32'(res_q);
            default:     rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q <= 32'd0;
        end else if (rd_en) begin
            d_out_q <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (wr_en && (state == S_IDLE)) begin
            if (bus.addr == ADDR_A) op_a_q <= bus.d_in[WIDTH-1:0];
            if (bus.addr == ADDR_B) op_b_q <= bus.d_in[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            res_q     <= '0;
            err       <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            // Later assignments below override this clear, so a capture wins over a STATUS read.
            if (rd_en && (bus.addr == ADDR_STATUS)) done_flag <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FIRE;
                        err       <= 1'b0;
                        done_flag <= 1'b0;
                    end
                end
                S_FIRE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.done) begin
                        state <= S_CAPT;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= S_DRAIN;
                    end
                end
                S_CAPT: begin
                    res_q     <= bus.result;
                    done_flag <= 1'b1;
                    state     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!bus.done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.d_out = d_out_q;
    assign bus.op_A  = op_a_q;
    assign bus.op_B  = op_b_q;
    assign bus.init  = (state == S_FIRE);
endmodule
